muldiv_multi_cycle: RTL and testbench
=====================================

# muldiv_multi_cycle

Iterative RV32M/RV64M multiply-divide unit for the multi-cycle RISC-V core. The controller stalls in an execute state for the duration of a request. The unit computes all eight M-extension operations with shift-add multiplication and restoring division, one bit per clock, behind a start/busy/done handshake. The width is parametrised. Divide-by-zero and signed overflow complete early with the architecturally defined results.

## Interface
- XLEN, 32, operand/result width; even, ≥ 4
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request strobe; accepted only when busy = 0
- kill  input  1  synchronous abort of an in-flight operation
- func3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  rs1 operand (multiplicand / dividend)
- b  input  XLEN  rs2 operand (multiplier / divisor)
- busy  output  1  high while state = CALC
- done  output  1  one-cycle pulse: result valid
- result  output  XLEN  registered result; held until the next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE or DONE with start = 1:
  - Latch func3, a, b.
  - Compute operand signs:
    - a is signed for MULH, MULHSU, DIV, REM.
    - b is signed for MULH, DIV, REM.
  - Store absolute values and a negate flag.
  - Clear the iteration counter (width $clog2(XLEN)+1).
  - Go to CALC, unless a special case applies.
- Special cases, detected at accept. These go straight to DONE and result is loaded at the accept edge.
  - DIV/DIVU with b = 0: result = all ones.
  - REM/REMU with b = 0: result = a.
  - DIV with a = 2^(XLEN-1) and b = all ones: result = a.
  - REM with a = 2^(XLEN-1) and b = all ones: result = 0.
- CALC, multiply:
  - 2·XLEN-bit product accumulator.
  - Each cycle: if multiplier LSB = 1, add the multiplicand into the upper half; then shift right 1.
  - Exactly XLEN iterations.
- CALC, divide (restoring):
  - Each cycle: shift {rem, quot} left 1; trial-subtract the divisor from rem.
  - If non-negative: keep the difference and set quot LSB = 1.
  - Exactly XLEN iterations.
- End of CALC (counter = XLEN-1 at the edge):
  - Apply sign correction:
    - Product: negate the full 2·XLEN-bit value if the signs differ.
    - Quotient: negate if the signs differ.
    - Remainder: takes the sign of a.
  - Select the output:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Write result; go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. A start in DONE is accepted as from IDLE.
- start while busy = 1: ignored; latched operands are unaffected.
- kill = 1 in CALC:
  - Next edge goes to IDLE.
  - No done; result keeps its previous value.
  - kill has priority over completion at the final iteration.
  - kill in IDLE/DONE has no effect. If kill and start arrive in the same cycle outside CALC, start is accepted.
- All arithmetic is modulo 2^XLEN on outputs; internal sums carry one guard bit.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, busy = 0, done = 0, result = 0, counter = 0. All internal datapath registers clear.
- Reset mid-CALC: immediate abort; no done after release.
- Start sampled at edge T (normal op):
  - busy = 1 after T through edge T+XLEN.
  - done = 1 in the cycle after edge T+XLEN.
  - Latency = XLEN+1 clocks to done.
- Special case: done = 1 in the cycle after edge T (latency 1); busy never rises.
- Back-to-back: start held high in the DONE cycle gives the next done XLEN+1 cycles later. Maximum throughput is one op per XLEN+1 cycles.
- Inputs a, b, func3 are sampled only at the accept edge; they may change freely afterwards.

## Test plan
- MUL, XLEN=32: a = 0x0000_0007, b = 0xFFFF_FFFD → done 33 cycles after start, result = 0xFFFF_FFEB. MULH of the same operands → 0xFFFF_FFFF; MULHU → 0x0000_0006; MULHSU → 0x0000_0006.
- DIV/REM signed: a = 0xFFFF_FFF9 (-7), b = 2 → DIV = 0xFFFF_FFFD (-3), REM = 0xFFFF_FFFF (-1). DIVU of the same operands = 0x7FFF_FFFC.
- Special cases, each with done one cycle after start and busy staying 0:
  - DIV a = 5, b = 0 → 0xFFFF_FFFF.
  - REMU a = 5, b = 0 → 5.
  - DIV a = 0x8000_0000, b = 0xFFFF_FFFF → 0x8000_0000.
  - REM of the same operands → 0.
- Handshake: a second start pulsed mid-CALC with different operands → ignored; the first result is returned. A start held high in the DONE cycle → second op accepted; its done follows 33 cycles later.
- Abort:
  - kill at iteration 10 → IDLE next cycle, no done, result unchanged.
  - rst low at iteration 20 → busy = 0, result = 0 immediately.
  - A fresh MULU 3×4 afterwards → 12.
- Parametrisation: XLEN = 8, DIVU 200/7 → 28; REMU → 4; done 9 cycles after start.

Source files
------------

// File: rtl/muldiv_multi_cycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muldiv_multi_cycle
// Brief    : Iterative RV32M/RV64M multiply/divide unit, one bit per clock
//            (shift-add multiply, restoring divide), start/busy/done handshake.
// Revision : 1.0
// ============================================================================
module muldiv_multi_cycle #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_CW   = $clog2(XLEN) + 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(XLEN - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [XLEN-1:0] c_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [2:0]        r_func3;
    logic              r_a_neg;
    logic              r_b_neg;
    logic [c_CW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_result;

    // ------------------------------------------------------------------
    // Accept-time decode: operand signs, magnitudes and early-out cases
    // ------------------------------------------------------------------
    logic            w_accept;
    logic            w_in_div;
    logic            w_a_sgn;
    logic            w_b_sgn;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept = start && (r_state != S_CALC);
    assign w_in_div = func3[2];
    assign w_a_sgn  = (func3 == 3'b001) || (func3 == 3'b010) ||
                      (func3 == 3'b100) || (func3 == 3'b110);
    assign w_b_sgn  = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    assign w_a_neg  = w_a_sgn && a[XLEN-1];
    assign w_b_neg  = w_b_sgn && b[XLEN-1];
    assign w_abs_a  = w_a_neg ? -a : a;
    assign w_abs_b  = w_b_neg ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = (a == c_MIN) && (b == c_ONES);

    always_comb begin
        w_special     = 1'b0;
        w_special_res = '0;
        if (w_in_div) begin
            if (w_b_zero) begin
                w_special     = 1'b1;
                w_special_res = func3[1] ? a : c_ONES;
            end else if (w_ovf && !func3[0]) begin
                w_special     = 1'b1;
                w_special_res = func3[1] ? '0 : a;
            end
        end
    end

    // ------------------------------------------------------------------
    // One iteration of multiply or divide on the shared accumulator
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [XLEN:0]     w_shrem;
    logic [XLEN:0]     w_trial;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [2*XLEN-1:0] w_div_nxt;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic              w_last;

    assign w_hi      = r_acc[2*XLEN-1:XLEN];
    assign w_lo      = r_acc[XLEN-1:0];
    assign w_sum     = {1'b0, w_hi} + {1'b0, r_opnd};
    assign w_add     = w_lo[0] ? w_sum : {1'b0, w_hi};
    assign w_mul_nxt = {w_add, w_lo[XLEN-1:1]};

    // The shifted partial remainder may carry into bit XLEN; that case is
    // always large enough to subtract, so only the borrow of the low part matters.
    assign w_shrem   = {w_hi, w_lo[XLEN-1]};
    assign w_trial   = w_shrem - {1'b0, r_opnd};
    assign w_ge      = w_shrem[XLEN] | ~w_trial[XLEN];
    assign w_rem_nxt = w_ge ? w_trial[XLEN-1:0] : w_shrem[XLEN-1:0];
    assign w_div_nxt = {w_rem_nxt, w_lo[XLEN-2:0], w_ge};

    assign w_acc_nxt = r_func3[2] ? w_div_nxt : w_mul_nxt;
    assign w_last    = (r_cnt == c_LAST);

    // ------------------------------------------------------------------
    // Sign correction and output select on the final iteration's value
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_nxt_hi;
    logic [XLEN-1:0]   w_nxt_lo;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_remd;
    logic [XLEN-1:0]   w_final;

    assign w_nxt_hi = w_acc_nxt[2*XLEN-1:XLEN];
    assign w_nxt_lo = w_acc_nxt[XLEN-1:0];
    assign w_prod   = (r_a_neg ^ r_b_neg) ? -w_acc_nxt : w_acc_nxt;
    assign w_quot   = (r_a_neg ^ r_b_neg) ? -w_nxt_lo : w_nxt_lo;
    assign w_remd   = r_a_neg ? -w_nxt_hi : w_nxt_hi;

    always_comb begin
        w_final = '0;
        case (r_func3)
            3'b000:                 w_final = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quot;
            default:                w_final = w_remd;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                // Abort wins even on the completing iteration.
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_func3  <= '0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_func3 <= func3;
            r_a_neg <= w_a_neg;
            r_b_neg <= w_b_neg;
            r_cnt   <= '0;
            // Divide: dividend in the low half, divisor held aside.
            // Multiply: multiplier in the low half, multiplicand held aside.
            r_acc   <= w_in_div ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
            r_opnd  <= w_in_div ? w_abs_b : w_abs_a;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if ((r_state == S_CALC) && !kill) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + c_ONE;
            if (w_last) begin
                r_result <= w_final;
            end
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_multi_cycle.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_multi_cycle
// Brief    : Scoreboard bench for muldiv_multi_cycle at XLEN=32 and XLEN=8.
// Revision : 1.0
// ============================================================================
module tb_muldiv_multi_cycle;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, kill32, busy32, done32;
    logic [2:0]  f32;
    logic [31:0] a32, b32, res32;
    logic        start8, kill8, busy8, done8;
    logic [2:0]  f8;
    logic [7:0]  a8, b8, res8;

    always #5 clk = ~clk;

    muldiv_multi_cycle #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .kill(kill32), .func3(f32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .result(res32)
    );

    muldiv_multi_cycle #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .kill(kill8), .func3(f8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8)
    );

    typedef struct {
        logic [31:0] val;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t m32;
    exp_t m8;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    // Monitors: every done pops one expectation (value and arrival cycle)
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done32: got done with result %h, want no done", res32);
            end else begin
                m32 = q32.pop_front();
                check({m32.nm, "_result"}, res32, m32.val);
                check({m32.nm, "_cycle"}, 32'(cyc), 32'(m32.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done8: got done with result %h, want no done", res8);
            end else begin
                m8 = q8.pop_front();
                check({m8.nm, "_result"}, {24'b0, res8}, m8.val);
                check({m8.nm, "_cycle"}, 32'(cyc), 32'(m8.cyc));
            end
        end
    end

    // Pulses start for one edge; returns #1 after the accepting edge
    task automatic drive(input int w, input logic [2:0] f, input logic [31:0] ia, input logic [31:0] ib);
        if (w == 8) begin
            start8 = 1'b1; f8 = f; a8 = ia[7:0]; b8 = ib[7:0];
        end else begin
            start32 = 1'b1; f32 = f; a32 = ia; b32 = ib;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic expect_res(input int w, input logic [31:0] v, input int lat, input string nm);
        exp_t e;
        e.val = v;
        e.cyc = cyc + lat;
        e.nm  = nm;
        if (w == 8) q8.push_back(e);
        else        q32.push_back(e);
    endtask

    task automatic op(input int w, input logic [2:0] f, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [31:0] v, input bit special, input string nm);
        logic bsy;
        @(negedge clk);
        drive(w, f, ia, ib);
        expect_res(w, v, special ? 0 : w, nm);
        bsy = (w == 8) ? busy8 : busy32;
        check({nm, "_busy"}, {31'b0, bsy}, special ? 32'd0 : 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while ((q32.size() + q8.size()) > 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if ((q32.size() + q8.size()) > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending results, want 0", q32.size() + q8.size());
            q32.delete();
            q8.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input int w, input logic [2:0] f, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] v, input bit special, input string nm);
        op(w, f, ia, ib, v, special, nm);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        start32 = 1'b0; kill32 = 1'b0; f32 = '0; a32 = '0; b32 = '0;
        start8  = 1'b0; kill8  = 1'b0; f8  = '0; a8  = '0; b8  = '0;
        #1;
        check("rst_result32", res32, 32'd0);
        check("rst_busy32", {31'b0, busy32}, 32'd0);
        check("rst_done32", {31'b0, done32}, 32'd0);
        check("rst_result8", {24'b0, res8}, 32'd0);
        check("rst_busy8", {31'b0, busy8}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Multiply family
        run(32, F_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "mul_7xm3");
        run(32, F_MULH,   32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "mulh_7xm3");
        run(32, F_MULHU,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 0, "mulhu_7xm3");
        run(32, F_MULHSU, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 0, "mulhsu_7xm3");
        run(32, F_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 0, "mul_shift");
        run(32, F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "mulhu_max");
        run(32, F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, "mulh_m1xm1");
        run(32, F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, "mulh_minxmin");

        // Divide family
        run(32, F_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, "div_m7_2");
        run(32, F_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, "rem_m7_2");
        run(32, F_DIVU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 0, "divu_big_2");
        run(32, F_REMU, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 0, "remu_big_2");
        run(32, F_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 0, "div_100_m7");
        run(32, F_REM,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 0, "rem_100_m7");

        // Early-out cases
        run(32, F_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 1, "div_by0");
        run(32, F_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run(32, F_REMU, 32'd5,         32'd0,         32'h0000_0005, 1, "remu_by0");
        run(32, F_REM,  32'd5,         32'd0,         32'h0000_0005, 1, "rem_by0");
        run(32, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(32, F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
        check("special_busy_after", {31'b0, busy32}, 32'd0);

        // Start while busy is ignored
        op(32, F_MUL, 32'd3, 32'd5, 32'd15, 0, "ign_first");
        repeat (5) @(negedge clk);
        drive(32, F_DIV, 32'd9, 32'd9);
        drain();

        // Start held in the DONE cycle is accepted
        op(32, F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "b2b_first");
        for (int k = 0; k < 100 && !done32; k++) @(negedge clk);
        check("b2b_done_seen", {31'b0, done32}, 32'd1);
        drive(32, F_REMU, 32'd100, 32'd7);
        expect_res(32, 32'd2, 32, "b2b_second");
        check("b2b_busy", {31'b0, busy32}, 32'd1);
        drain();

        // Kill at iteration 10
        @(negedge clk);
        drive(32, F_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        kill32 = 1'b1;
        @(posedge clk);
        #1;
        kill32 = 1'b0;
        check("kill10_busy", {31'b0, busy32}, 32'd0);
        check("kill10_result", res32, 32'd2);
        repeat (40) @(negedge clk);
        check("kill10_result_later", res32, 32'd2);

        // Kill on the completing edge
        @(negedge clk);
        drive(32, F_MUL, 32'd6, 32'd7);
        repeat (32) @(negedge clk);
        check("killlast_busy_pre", {31'b0, busy32}, 32'd1);
        kill32 = 1'b1;
        @(posedge clk);
        #1;
        kill32 = 1'b0;
        check("killlast_busy", {31'b0, busy32}, 32'd0);
        check("killlast_result", res32, 32'd2);
        repeat (5) @(negedge clk);

        // Kill together with start outside CALC: start wins
        @(negedge clk);
        kill32 = 1'b1;
        drive(32, F_DIVU, 32'd100, 32'd7);
        kill32 = 1'b0;
        expect_res(32, 32'd14, 32, "kill_with_start");
        check("kill_with_start_busy", {31'b0, busy32}, 32'd1);
        drain();

        // Reset in the middle of a calculation
        @(negedge clk);
        drive(32, F_MUL, 32'h0000_1234, 32'h0000_5678);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy32}, 32'd0);
        check("midrst_result", res32, 32'd0);
        check("midrst_done", {31'b0, done32}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_busy_later", {31'b0, busy32}, 32'd0);
        run(32, F_MUL, 32'd3, 32'd4, 32'd12, 0, "mul_after_rst");

        // XLEN = 8
        run(8, F_DIVU,   32'd200,  32'd7,    32'd28,   0, "x8_divu");
        run(8, F_REMU,   32'd200,  32'd7,    32'd4,    0, "x8_remu");
        run(8, F_DIV,    32'h9C,   32'd7,    32'hF2,   0, "x8_div");
        run(8, F_REM,    32'h9C,   32'd7,    32'hFE,   0, "x8_rem");
        run(8, F_MULH,   32'h80,   32'h80,   32'h40,   0, "x8_mulh");
        run(8, F_MULHSU, 32'hFF,   32'hFF,   32'hFF,   0, "x8_mulhsu");
        run(8, F_DIV,    32'h80,   32'hFF,   32'h80,   1, "x8_div_ovf");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
